// File: rtl/neo_spr_pkg.sv
// Shared sprite-pipeline types and constants: draw FSM states and the
// horizontal-shrink mask table used by the X-position/shrink stage.
package neo_spr_pkg;

  localparam int SPR_TILE_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } spr_state_e;

  // Entry s draws s+1 pixels. Each entry adds one pixel to the previous
  // entry, spreading them across the tile so a narrow sprite samples the
  // whole tile instead of only its left edge.
  localparam logic [15:0] HSHRINK_TABLE [16] = '{
    16'h0100, 16'h0101, 16'h1101, 16'h1111,
    16'h1511, 16'h1515, 16'h5515, 16'h5555,
    16'h5755, 16'h5757, 16'h7757, 16'h7777,
    16'h7F77, 16'h7F7F, 16'hFF7F, 16'hFFFF
  };

endpackage

// File: rtl/spr_hshrink_xpos_if.sv
// Sprite parameter handshake from the third stage of the sprite pipeline.
interface spr_hshrink_xpos_if #(
  parameter int XW = 9
);
  logic          spr_valid;
  logic          spr_ready;
  logic          spr_chain;
  logic [3:0]    spr_hshrink;
  logic [XW-1:0] spr_xpos;

  modport master (
    output spr_valid, spr_chain, spr_hshrink, spr_xpos,
    input  spr_ready
  );

  modport slave (
    input  spr_valid, spr_chain, spr_hshrink, spr_xpos,
    output spr_ready
  );
endinterface

// File: rtl/hshrink_mask_rom.sv
// Combinational lookup: 4-bit horizontal shrink to 16-pixel draw mask.
module hshrink_mask_rom
  import neo_spr_pkg::*;
(
  input  logic [3:0]  hshrink,
  output logic [15:0] mask
);

  assign mask = HSHRINK_TABLE[hshrink];

endmodule

// File: rtl/spr_hshrink_xpos.sv
// Resolves sprite X (absolute or chained), expands the shrink mask and steps
// the 16 tile pixels at pixel rate, producing line-buffer writes.
module spr_hshrink_xpos
  import neo_spr_pkg::*;
#(
  parameter int XW     = 9,
  parameter int TILE_W = SPR_TILE_W
) (
  input  logic                CLK,
  input  logic                RESETP,
  input  logic                pix_en,
  input  logic                new_line,
  input  logic                flip,
  spr_hshrink_xpos_if.slave   spr,
  output logic [XW-1:0]       x_start,
  output logic                lb_we,
  output logic [XW-1:0]       lb_addr,
  output logic [3:0]          pix_idx,
  output logic                spr_done
);

  localparam int SW = $clog2(TILE_W);

  spr_state_e    state, state_nxt;
  logic [SW-1:0] step;
  logic [15:0]   mask;
  logic [XW-1:0] cur;
  logic [XW-1:0] prev_x;
  logic [4:0]    prev_w;

  logic          accept;
  logic          draw_step;
  logic          last_step;
  logic [SW-1:0] pix_sel;
  logic [XW-1:0] x_new;
  logic [15:0]   rom_mask;

  hshrink_mask_rom u_mask_rom (
    .hshrink (spr.spr_hshrink),
    .mask    (rom_mask)
  );

  assign spr.spr_ready = (state == IDLE);

  // A chained sprite starts where the previous one stopped drawing.
  assign x_new   = spr.spr_chain ? (prev_x + XW'(prev_w)) : spr.spr_xpos;
  assign pix_sel = flip ? (SW'(TILE_W - 1) - step) : step;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    state_nxt = state;
    accept    = 1'b0;
    draw_step = 1'b0;
    last_step = 1'b0;
    unique case (state)
      IDLE: begin
        if (spr.spr_valid && !new_line) begin
          accept    = 1'b1;
          state_nxt = DRAW;
        end
      end
      DRAW: begin
        if (pix_en && !new_line) begin
          draw_step = 1'b1;
          if (step == SW'(TILE_W - 1)) begin
            last_step = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
    endcase
    if (new_line) state_nxt = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RESETP) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge CLK) begin
    if (!RESETP) begin
      x_start  <= '0;
      lb_we    <= 1'b0;
      lb_addr  <= '0;
      pix_idx  <= '0;
      spr_done <= 1'b0;
      step     <= '0;
      mask     <= '0;
      cur      <= '0;
      prev_x   <= '0;
      prev_w   <= '0;
    end else begin
      lb_we    <= 1'b0;
      spr_done <= 1'b0;
      if (new_line) begin
        prev_x <= '0;
        prev_w <= '0;
      end else if (accept) begin
        x_start <= x_new;
        prev_x  <= x_new;
        prev_w  <= 5'(spr.spr_hshrink) + 5'd1;
        mask    <= rom_mask;
        step    <= '0;
        cur     <= x_new;
      end else if (draw_step) begin
        pix_idx <= 4'(pix_sel);
        if (mask[pix_sel]) begin
          lb_we   <= 1'b1;
          lb_addr <= cur;
          cur     <= cur + XW'(1);
        end
        step <= step + SW'(1);
        if (last_step) spr_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spr_hshrink_xpos.sv
// Self-checking bench: a per-sprite write-list model compared every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_spr_hshrink_xpos;

  logic       CLK;
  logic       RESETP;
  logic       pix_en;
  logic       new_line;
  logic       flip;
  logic [8:0] x_start;
  logic       lb_we;
  logic [8:0] lb_addr;
  logic [3:0] pix_idx;
  logic       spr_done;

  spr_hshrink_xpos_if #(.XW(9)) spr_bus ();

  spr_hshrink_xpos #(.XW(9), .TILE_W(16)) dut (
    .CLK      (CLK),
    .RESETP   (RESETP),
    .pix_en   (pix_en),
    .new_line (new_line),
    .flip     (flip),
    .spr      (spr_bus),
    .x_start  (x_start),
    .lb_we    (lb_we),
    .lb_addr  (lb_addr),
    .pix_idx  (pix_idx),
    .spr_done (spr_done)
  );

  logic [3:0]  rom_sel;
  logic [15:0] rom_out;
  hshrink_mask_rom ref_rom (.hshrink(rom_sel), .mask(rom_out));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic       we;
    logic [8:0] addr;
    logic [3:0] pix;
  } step_t;

  logic [15:0] tbl [16];
  step_t       q[$];
  logic        m_busy;
  int          m_px, m_pw;
  logic        e_we, e_done;
  logic [8:0]  e_addr, e_xs;
  logic [3:0]  e_pix;
  logic        cmp_en = 1'b0;
  int          cyc = 0;

  // Per sprite: the full ordered list of 16 steps, each either a write to
  // the next address or a skipped pixel; one list entry is consumed per pixel.
  always @(posedge CLK) begin
    step_t e;
    int    a, p;
    cyc++;
    if (!RESETP) begin
      m_busy = 1'b0; m_px = 0; m_pw = 0;
      e_we = 1'b0; e_done = 1'b0; e_addr = '0; e_xs = '0; e_pix = '0;
      q.delete();
    end else begin
      e_we   = 1'b0;
      e_done = 1'b0;
      if (new_line) begin
        m_busy = 1'b0; m_px = 0; m_pw = 0;
        q.delete();
      end else if (!m_busy) begin
        if (spr_bus.spr_valid) begin
          a = spr_bus.spr_chain ? (m_px + m_pw) % 512 : int'(spr_bus.spr_xpos);
          e_xs = 9'(a);
          m_px = a;
          m_pw = int'(spr_bus.spr_hshrink) + 1;
          q.delete();
          for (int k = 0; k < 16; k++) begin
            p = flip ? 15 - k : k;
            e.pix = 4'(p);
            e.we  = tbl[spr_bus.spr_hshrink][p];
            e.addr = 9'(a);
            if (e.we) a = (a + 1) % 512;
            q.push_back(e);
          end
          m_busy = 1'b1;
        end
      end else if (pix_en) begin
        e = q.pop_front();
        e_pix = e.pix;
        if (e.we) begin
          e_we   = 1'b1;
          e_addr = e.addr;
        end
        if (q.size() == 0) begin
          e_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      check("ready",    32'(spr_bus.spr_ready), 32'(!m_busy));
      check("lb_we",    32'(lb_we),    32'(e_we));
      check("lb_addr",  32'(lb_addr),  32'(e_addr));
      check("pix_idx",  32'(pix_idx),  32'(e_pix));
      check("spr_done", 32'(spr_done), 32'(e_done));
      check("x_start",  32'(x_start),  32'(e_xs));
    end
  end

  // ---------------- write log for literal checks ----------------
  typedef struct {
    logic [8:0] addr;
    logic [3:0] pix;
    int         cyc;
  } wr_t;

  wr_t log_q[$];
  int  done_cnt = 0;
  int  acc_cyc  = 0;

  always @(negedge CLK) begin
    wr_t w;
    if (lb_we === 1'b1) begin
      w.addr = lb_addr; w.pix = pix_idx; w.cyc = cyc;
      log_q.push_back(w);
    end
    if (spr_done === 1'b1) done_cnt++;
  end

  function automatic int log_addr(input int i);
    return (i < log_q.size()) ? int'(log_q[i].addr) : -1;
  endfunction

  function automatic int log_pix(input int i);
    return (i < log_q.size()) ? int'(log_q[i].pix) : -1;
  endfunction

  function automatic int log_dcyc(input int i);
    return (i < log_q.size()) ? log_q[i].cyc - acc_cyc : -1;
  endfunction

  task automatic clear_log();
    log_q.delete();
    done_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic send(input logic chain, input logic [3:0] hs, input logic [8:0] xp);
    spr_bus.spr_chain   = chain;
    spr_bus.spr_hshrink = hs;
    spr_bus.spr_xpos    = xp;
    spr_bus.spr_valid   = 1'b1;
    tick(1);
    acc_cyc = cyc;
    spr_bus.spr_valid = 1'b0;
  endtask

  initial begin
    int pc;
    bit got;
    RESETP   = 1'b0;
    pix_en   = 1'b0;
    new_line = 1'b0;
    flip     = 1'b0;
    spr_bus.spr_valid   = 1'b0;
    spr_bus.spr_chain   = 1'b0;
    spr_bus.spr_hshrink = '0;
    spr_bus.spr_xpos    = '0;

    // Mask table: endpoints, popcount s+1, each entry contained in the next.
    for (int s = 0; s < 16; s++) begin
      rom_sel = 4'(s);
      #1;
      tbl[s] = rom_out;
      check("mask_popcount", 32'($countones(rom_out)), 32'(s + 1));
    end
    check("mask_0",  32'(tbl[0]),  32'h0100);
    check("mask_15", 32'(tbl[15]), 32'hFFFF);
    for (int s = 0; s < 15; s++)
      check("mask_subset", 32'(tbl[s] & ~tbl[s + 1]), 32'h0);

    tick(2);
    cmp_en = 1'b1;
    check("rst_ready", 32'(spr_bus.spr_ready), 32'h1);
    check("rst_we",    32'(lb_we), 32'h0);
    check("rst_xs",    32'(x_start), 32'h0);
    RESETP = 1'b1;
    tick(1);

    // 1: unchained, X=100, full width
    pix_en = 1'b1;
    clear_log();
    send(1'b0, 4'd15, 9'd100);
    tick(17);
    check("t1_xs",    32'(x_start), 32'd100);
    check("t1_count", 32'(log_q.size()), 32'd16);
    check("t1_first", 32'(log_addr(0)), 32'd100);
    check("t1_last",  32'(log_addr(15)), 32'd115);
    check("t1_pix0",  32'(log_pix(0)), 32'd0);
    check("t1_pix15", 32'(log_pix(15)), 32'd15);
    check("t1_done",  32'(done_cnt), 32'd1);
    check("t1_lat",   32'(log_dcyc(0)), 32'd1);

    // 2: X=40 width 4, then chained width 8 -> starts at 44
    send(1'b0, 4'd3, 9'd40);
    tick(17);
    clear_log();
    send(1'b1, 4'd7, 9'd300);
    tick(17);
    check("t2_xs",    32'(x_start), 32'd44);
    check("t2_count", 32'(log_q.size()), 32'd8);
    check("t2_first", 32'(log_addr(0)), 32'd44);
    check("t2_last",  32'(log_addr(7)), 32'd51);

    // 3: single pixel at X=511, normal then flipped
    clear_log();
    send(1'b0, 4'd0, 9'd511);
    tick(17);
    check("t3_count", 32'(log_q.size()), 32'd1);
    check("t3_addr",  32'(log_addr(0)), 32'd511);
    check("t3_pix",   32'(log_pix(0)), 32'd8);
    check("t3_step",  32'(log_dcyc(0)), 32'd9);
    flip = 1'b1;
    clear_log();
    send(1'b0, 4'd0, 9'd511);
    tick(17);
    check("t3f_count", 32'(log_q.size()), 32'd1);
    check("t3f_pix",   32'(log_pix(0)), 32'd8);
    check("t3f_step",  32'(log_dcyc(0)), 32'd8);
    flip = 1'b0;

    // 4: address wrap 508..511,0..11; a VALID during DRAW is ignored
    clear_log();
    send(1'b0, 4'd15, 9'd508);
    tick(3);
    spr_bus.spr_valid = 1'b1; spr_bus.spr_xpos = 9'd5; spr_bus.spr_hshrink = 4'd2;
    tick(3);
    spr_bus.spr_valid = 1'b0;
    tick(11);
    check("t4_count", 32'(log_q.size()), 32'd16);
    check("t4_a3",    32'(log_addr(3)), 32'd511);
    check("t4_a4",    32'(log_addr(4)), 32'd0);
    check("t4_a15",   32'(log_addr(15)), 32'd11);
    check("t4_xs",    32'(x_start), 32'd508);

    // 5: NEW_LINE at step 5 with VALID high; following chained sprite at 0
    clear_log();
    send(1'b0, 4'd15, 9'd200);
    tick(5);
    new_line = 1'b1;
    spr_bus.spr_valid = 1'b1; spr_bus.spr_chain = 1'b0; spr_bus.spr_xpos = 9'd77;
    tick(1);
    new_line = 1'b0;
    spr_bus.spr_valid = 1'b0;
    check("t5_ready", 32'(spr_bus.spr_ready), 32'h1);
    check("t5_xs",    32'(x_start), 32'd200);
    tick(3);
    check("t5_count", 32'(log_q.size()), 32'd5);
    check("t5_done",  32'(done_cnt), 32'd0);
    clear_log();
    send(1'b1, 4'd5, 9'd123);
    tick(17);
    check("t5c_xs",    32'(x_start), 32'd0);
    check("t5c_count", 32'(log_q.size()), 32'd6);
    check("t5c_first", 32'(log_addr(0)), 32'd0);

    // 6: reset mid-DRAW
    send(1'b0, 4'd15, 9'd300);
    tick(4);
    RESETP = 1'b0;
    tick(1);
    clear_log();
    check("t6_ready", 32'(spr_bus.spr_ready), 32'h1);
    check("t6_we",    32'(lb_we), 32'h0);
    check("t6_addr",  32'(lb_addr), 32'h0);
    check("t6_pix",   32'(pix_idx), 32'h0);
    check("t6_xs",    32'(x_start), 32'h0);
    check("t6_done",  32'(spr_done), 32'h0);
    RESETP = 1'b1;
    tick(3);
    check("t6_nowr",  32'(log_q.size()), 32'd0);

    // 7: random PIX_EN gaps, unflipped then flipped chained sprite
    for (int t = 0; t < 2; t++) begin
      flip = t[0];
      clear_log();
      if (t == 0) send(1'b0, 4'd9, 9'd50);
      else        send(1'b1, 4'd4, 9'd0);
      got = 1'b0;
      pc  = 0;
      while (!got && pc < 200) begin
        pix_en = 1'($urandom_range(0, 1));
        tick(1);
        pc++;
        if (done_cnt != 0) got = 1'b1;
      end
      check("t7_timeout", 32'(got), 32'h1);
      check("t7_count",   32'(log_q.size()), (t == 0) ? 32'd10 : 32'd5);
      check("t7_first",   32'(log_addr(0)), (t == 0) ? 32'd50 : 32'd60);
      check("t7_done",    32'(done_cnt), 32'd1);
    end
    pix_en = 1'b1;
    flip   = 1'b0;
    tick(2);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
